// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_e;

    localparam int LOSS_CNT_W = 8;

    // Bits needed to hold the values 0 .. n-1, never fewer than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the lock supervisor and its PLL / downstream logic.
// master: the supervisor side. slave: the PLL wrapper / consumer side.
interface pll_lock_supervisor_if
    import pll_sup_pkg::*;
#(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = cnt_w(MAX_RETRIES + 1);

    logic                  pll_locked;
    logic                  pll_rst;
    logic                  sys_rst_n;
    logic                  lock_ok;
    logic                  fault;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] lock_loss_count;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst_n, lock_ok, fault, retry_cnt, lock_loss_count
    );

    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst_n, lock_ok, fault, retry_cnt, lock_loss_count
    );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock flag, with a
// synchronous active-low clear so a reset never leaves a stale "locked".
module pll_lock_sync (
    input  logic refclk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    // Two-stage capture into the refclk domain; cleared by rst.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock, qualifies it
// for a programmed number of cycles, then releases sys_rst_n. Lock loss in
// RUN re-arms the PLL; repeated lock timeouts end in a sticky fault.
// Optional build macro PLL_SUPERVISOR_LOSS_COUNT_EN enables a saturating
// lock-loss event counter; without it lock_loss_count is tied to zero.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int STABLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 3
) (
    input logic                   refclk,
    input logic                   rst,
    pll_lock_supervisor_if.master bus
);
    localparam int PULSE_W   = cnt_w(RST_PULSE_CYCLES);
    localparam int TIMEOUT_W = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int STABLE_W  = cnt_w(STABLE_CYCLES);
    localparam int RETRY_W   = cnt_w(MAX_RETRIES + 1);
    // One shared phase counter; only one phase is active at a time.
    localparam int CNT_W = (PULSE_W > TIMEOUT_W)
                         ? ((PULSE_W > STABLE_W) ? PULSE_W : STABLE_W)
                         : ((TIMEOUT_W > STABLE_W) ? TIMEOUT_W : STABLE_W);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

    sup_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RETRY_W-1:0] retry, retry_n;
    logic               locked_s;
    logic               pll_rst_q, sys_rst_n_q, lock_ok_q, fault_q;

    pll_lock_sync u_sync (
        .refclk (refclk),
        .rst    (rst),
        .d      (bus.pll_locked),
        .q      (locked_s)
    );

    // Next-state and counter update; each counter restarts on state exit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry;
        case (state)
            RESET_PLL: begin
                if (cnt == PULSE_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_n = '0;
                    if (retry == RETRY_LAST) begin
                        state_n = FAULT;
                    end else begin
                        state_n = RESET_PLL;
                        retry_n = retry + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STABLE: begin
                // Any drop restarts qualification without spending a retry.
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RUN: begin
                // Lock loss opens a fresh episode with a full retry budget.
                if (!locked_s) begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                    retry_n = '0;
                end
            end
            FAULT: begin
                state_n = FAULT;
                cnt_n   = '0;
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
                retry_n = '0;
            end
        endcase
    end

    // State/counter registers and registered outputs decoded from next state.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            retry       <= retry_n;
            pll_rst_q   <= (state_n == RESET_PLL) || (state_n == FAULT);
            sys_rst_n_q <= (state_n == RUN);
            lock_ok_q   <= (state_n == RUN);
            fault_q     <= (state_n == FAULT);
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.lock_ok   = lock_ok_q;
    assign bus.fault     = fault_q;
    assign bus.retry_cnt = retry;

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    logic                  loss_event;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    assign loss_event = (state == RUN) && !locked_s;

    // Saturating lock-loss tally; survives re-arming, cleared only by rst.
    always_ff @(posedge refclk) begin
        if (!rst) begin
            loss_cnt <= '0;
        end else if (loss_event && (loss_cnt != '1)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign bus.lock_loss_count = loss_cnt;
`else
    assign bus.lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a cycle model of the
// supervision rules and hand-computed edge-exact expectations.
module tb_pll_lock_supervisor;

    localparam int P_PULSE   = 4;
    localparam int P_TIMEOUT = 50;
    localparam int P_STABLE  = 8;
    localparam int P_RETRIES = 2;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam int MD_PULSE = 0;
    localparam int MD_WAIT  = 1;
    localparam int MD_QUAL  = 2;
    localparam int MD_RUN   = 3;
    localparam int MD_FAULT = 4;

    logic refclk = 1'b0;
    logic rst;

    pll_lock_supervisor_if #(.MAX_RETRIES(P_RETRIES)) bus ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (P_PULSE),
        .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
        .STABLE_CYCLES       (P_STABLE),
        .MAX_RETRIES         (P_RETRIES)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int tests = 0;
    int fails = 0;
    int edge_no = 0;

    // Model: mode, cycles shown in the current mode, qualified run length,
    // retries, losses, and the two synchronizer samples.
    int m_mode = MD_PULSE;
    int m_spent = 1;
    int m_run = 0;
    int m_retries = 0;
    int m_losses = 0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_update(input logic r, input logic l);
        bit ls;
        if (!r) begin
            m_mode = MD_PULSE; m_spent = 1; m_run = 0;
            m_retries = 0; m_losses = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = l;
            case (m_mode)
                MD_PULSE: begin
                    if (m_spent == P_PULSE) begin m_mode = MD_WAIT; m_spent = 1; end
                    else m_spent++;
                end
                MD_WAIT: begin
                    if (ls) begin
                        m_mode = MD_QUAL; m_run = 0;
                    end else if (m_spent == P_TIMEOUT) begin
                        if (m_retries == P_RETRIES) m_mode = MD_FAULT;
                        else begin m_retries++; m_mode = MD_PULSE; m_spent = 1; end
                    end else begin
                        m_spent++;
                    end
                end
                MD_QUAL: begin
                    if (!ls) begin
                        m_mode = MD_WAIT; m_spent = 1;
                    end else begin
                        m_run++;
                        if (m_run == P_STABLE) m_mode = MD_RUN;
                    end
                end
                MD_RUN: begin
                    if (!ls) begin
                        m_mode = MD_PULSE; m_spent = 1; m_retries = 0;
                        if (LOSS_EN) m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_model();
        chk("model_pll_rst", int'(bus.pll_rst), int'(m_mode == MD_PULSE || m_mode == MD_FAULT));
        chk("model_sys_rst_n", int'(bus.sys_rst_n), int'(m_mode == MD_RUN));
        chk("model_lock_ok", int'(bus.lock_ok), int'(m_mode == MD_RUN));
        chk("model_fault", int'(bus.fault), int'(m_mode == MD_FAULT));
        chk("model_retry_cnt", int'(bus.retry_cnt), m_retries);
        chk("model_lock_loss_count", int'(bus.lock_loss_count), m_losses);
    endtask

    // One refclk cycle: drive inputs, advance model at the edge, check after.
    task automatic step(input logic r, input logic l);
        rst = r;
        bus.pll_locked = l;
        @(posedge refclk);
        model_update(r, l);
        if (!r) edge_no = 0;
        else edge_no++;
        @(negedge refclk);
        compare_model();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_rst"}, int'(bus.pll_rst), 1);
        chk({tag, "_sys_rst_n"}, int'(bus.sys_rst_n), 0);
        chk({tag, "_lock_ok"}, int'(bus.lock_ok), 0);
        chk({tag, "_fault"}, int'(bus.fault), 0);
        chk({tag, "_retry_cnt"}, int'(bus.retry_cnt), 0);
        chk({tag, "_loss"}, int'(bus.lock_loss_count), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.pll_locked = 1'b0;
        @(negedge refclk);

        // Normal lock
        step(1'b0, 1'b0);
        chk_reset_values("s1_reset");
        for (int e = 1; e <= 25; e++) begin
            step(1'b1, e >= 10);
            if (e == 3) chk("s1_pll_rst_e3", int'(bus.pll_rst), 1);
            if (e == 4) chk("s1_pll_rst_e4", int'(bus.pll_rst), 0);
            if (e == 19) chk("s1_sys_rst_n_e19", int'(bus.sys_rst_n), 0);
            if (e == 20) begin
                chk("s1_sys_rst_n_e20", int'(bus.sys_rst_n), 1);
                chk("s1_lock_ok_e20", int'(bus.lock_ok), 1);
                chk("s1_retry_e20", int'(bus.retry_cnt), 0);
            end
        end

        // One-cycle glitch five cycles into qualification
        step(1'b0, 1'b0);
        for (int e = 1; e <= 32; e++) begin
            step(1'b1, (e >= 10) && (e != 17));
            if (e == 20) chk("s2_sys_rst_n_e20", int'(bus.sys_rst_n), 0);
            if (e == 27) chk("s2_sys_rst_n_e27", int'(bus.sys_rst_n), 0);
            if (e == 28) begin
                chk("s2_sys_rst_n_e28", int'(bus.sys_rst_n), 1);
                chk("s2_retry_e28", int'(bus.retry_cnt), 0);
            end
        end

        // Lock timeout with retries, then fault
        step(1'b0, 1'b0);
        for (int e = 1; e <= 200; e++) begin
            step(1'b1, 1'b0);
            if (e == 53) begin
                chk("s3_pll_rst_e53", int'(bus.pll_rst), 0);
                chk("s3_retry_e53", int'(bus.retry_cnt), 0);
            end
            if (e == 54) begin
                chk("s3_pll_rst_e54", int'(bus.pll_rst), 1);
                chk("s3_retry_e54", int'(bus.retry_cnt), 1);
            end
            if (e == 57) chk("s3_pll_rst_e57", int'(bus.pll_rst), 1);
            if (e == 58) chk("s3_pll_rst_e58", int'(bus.pll_rst), 0);
            if (e == 107) chk("s3_retry_e107", int'(bus.retry_cnt), 1);
            if (e == 108) chk("s3_retry_e108", int'(bus.retry_cnt), 2);
            if (e == 161) chk("s3_fault_e161", int'(bus.fault), 0);
            if (e == 162) begin
                chk("s3_fault_e162", int'(bus.fault), 1);
                chk("s3_pll_rst_e162", int'(bus.pll_rst), 1);
            end
            if (e == 200) begin
                chk("s3_fault_e200", int'(bus.fault), 1);
                chk("s3_pll_rst_e200", int'(bus.pll_rst), 1);
                chk("s3_sys_rst_n_e200", int'(bus.sys_rst_n), 0);
            end
        end

        // Reset from FAULT clears the sticky fault
        step(1'b0, 1'b0);
        chk_reset_values("s5_fault");

        // Reset during WAIT_LOCK
        for (int e = 1; e <= 10; e++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk_reset_values("s5_wait");

        // Reset during STABLE, then relock from a cleared synchronizer
        for (int e = 1; e <= 15; e++) step(1'b1, e >= 10);
        step(1'b0, 1'b1);
        chk_reset_values("s5_stable");
        for (int e = 1; e <= 14; e++) begin
            step(1'b1, 1'b1);
            if (e == 12) chk("s5_relock_e12", int'(bus.sys_rst_n), 0);
            if (e == 13) chk("s5_relock_e13", int'(bus.sys_rst_n), 1);
        end

        // Lock loss in RUN and recovery
        step(1'b0, 1'b0);
        for (int e = 1; e <= 50; e++) begin
            step(1'b1, (e >= 10) && !(e >= 30 && e <= 32));
            if (e == 31) chk("s4_sys_rst_n_e31", int'(bus.sys_rst_n), 1);
            if (e == 32) begin
                chk("s4_sys_rst_n_e32", int'(bus.sys_rst_n), 0);
                chk("s4_lock_ok_e32", int'(bus.lock_ok), 0);
                chk("s4_pll_rst_e32", int'(bus.pll_rst), 1);
                chk("s4_retry_e32", int'(bus.retry_cnt), 0);
            end
            if (e == 35) chk("s4_pll_rst_e35", int'(bus.pll_rst), 1);
            if (e == 36) chk("s4_pll_rst_e36", int'(bus.pll_rst), 0);
            if (e == 44) chk("s4_sys_rst_n_e44", int'(bus.sys_rst_n), 0);
            if (e == 45) begin
                chk("s4_sys_rst_n_e45", int'(bus.sys_rst_n), 1);
                chk("s4_lock_ok_e45", int'(bus.lock_ok), 1);
                chk("s4_loss_e45", int'(bus.lock_loss_count), LOSS_EN ? 1 : 0);
            end
        end
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
            for (int j = 0; j < 15; j++) step(1'b1, 1'b1);
        end
        chk("s4_sys_rst_n_end", int'(bus.sys_rst_n), 1);
        chk("s4_loss_saturated", int'(bus.lock_loss_count), LOSS_EN ? 255 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises a PLL on its reference clock.
- Drives the PLL reset and consumes the PLL lock flag.
- Releases a clean, synchronous, active-low system reset to downstream logic only after lock has held for a programmed time.
- Re-arms the PLL on lock loss or lock timeout, with bounded retries and a sticky fault.
- Sits beside every PLL wrapper instance, fed by the same reference clock.

Parameters:
RST_PULSE_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=2)
LOCK_TIMEOUT_CYCLES, 27000, max cycles to wait for lock after pll_rst falls (1 ms at 27 MHz, >=2)
STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before reset release (>=2)
MAX_RETRIES, 3, PLL reset retries after the first attempt before fault (>=0)

Ports:
refclk  in  1  reference clock; all logic is in this domain
rst  in  1  synchronous, active-low reset (sampled on refclk rising edge)
pll_locked  in  1  PLL lock flag, asynchronous to refclk
pll_rst  out  1  active-high reset to PLL
sys_rst_n  out  1  active-low reset for downstream logic
lock_ok  out  1  high while in RUN
fault  out  1  sticky; lock never achieved within retry budget
retry_cnt  out  $clog2(MAX_RETRIES+1)  retries used in current episode
lock_loss_count  out  8  lock-loss events in RUN (see Optional Feature)

Behaviour:
- Synchronizer: pll_locked passes through 2 flops to give locked_s. An edge on pll_locked seen at refclk edge k appears on locked_s after edge k+1.
- Reset (rst=0 at an edge) dominates all other events. Next state is RESET_PLL; all counters are 0.
  - Outputs: pll_rst=1, sys_rst_n=0, lock_ok=0, fault=0, retry_cnt=0, lock_loss_count=0.
  - The synchronizer flops clear to 0.
- All outputs are registered, and each is a pure function of state and counters.
- States:
  - RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with timer=0.
  - WAIT_LOCK: pll_rst=0; timer increments each cycle.
    - locked_s=1: go to STABLE with stable counter=0.
    - Timer reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0: if retry_cnt==MAX_RETRIES go to FAULT, else retry_cnt+1 and go to RESET_PLL.
  - STABLE: stable counter increments while locked_s=1.
    - locked_s=0: go to WAIT_LOCK with timer reset; retry_cnt is unchanged.
    - Counter reaches STABLE_CYCLES-1: go to RUN. Net effect: sys_rst_n=1 at edge k+2+STABLE_CYCLES, where k is the first edge at which the synchronizer samples pll_locked=1.
  - RUN: sys_rst_n=1, lock_ok=1.
    - locked_s=0: go to RESET_PLL. On that edge sys_rst_n=0, lock_ok=0 and retry_cnt=0 (new episode); this is a lock-loss event.
  - FAULT: fault=1, pll_rst=1, sys_rst_n=0, lock_ok=0. Terminal until rst.
- Lock must be continuous: a single-cycle drop of locked_s in STABLE restarts qualification.
- Widths: each counter is $clog2 of its terminal count. Counters never wrap; each is cleared on its state exit.
- Illegal or unused state encodings recover to RESET_PLL.

Optional Feature:
PLL_SUPERVISOR_LOSS_COUNT_EN
- Defined: lock_loss_count increments on each RUN to RESET_PLL transition, saturates at 255, and clears only on rst.
- Undefined: lock_loss_count is tied to 0 and no counter is synthesized. The port is present in both builds.

Decomposition:
- Package pll_sup_pkg holds:
  - the state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT);
  - the LOSS_CNT_W=8 constant;
  - a counter-width helper function.
- One sub-module, pll_lock_sync: 2-flop synchronizer with synchronous active-low clear, instantiated for pll_locked.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal lock: release rst at edge 0, pll_locked=1 from edge 10 -> pll_rst high edges 0-3, low at 4; sys_rst_n=1 and lock_ok=1 at edge 20; retry_cnt=0.
2. Glitch in STABLE: pll_locked low 1 cycle, 5 cycles into STABLE -> sys_rst_n stays 0; released STABLE_CYCLES+2 edges after pll_locked returns high; retry_cnt unchanged.
3. Timeout: pll_locked held 0 -> three pll_rst pulses of 4 cycles; retry_cnt goes 1 then 2; fault=1 after 3*(4+50) cycles; pll_rst held 1 thereafter.
4. Lock loss in RUN: drop pll_locked -> sys_rst_n=0 and lock_ok=0 within 3 edges; 4-cycle pll_rst pulse; relock gives sys_rst_n=1 again.
   - Macro defined: lock_loss_count=1.
   - Repeat 300 times: count saturates at 255.
5. Reset mid-operation: assert rst for 1 edge in WAIT_LOCK, STABLE and FAULT -> next edge shows the full reset values; fault clears.
6. Macro undefined: rerun scenario 4 -> lock_loss_count remains 0 throughout.
